// File: rtl/img_chunk_buf_if.sv
// Chunk output stream between the image buffer and downstream processing.
interface img_chunk_buf_if #(parameter int CHUNK_W = 96);
  logic [CHUNK_W-1:0] m_data;
  logic               m_vld;
  logic               m_rdy;
  logic               m_last;
  logic               m_user;

  modport master (output m_data, m_vld, m_last, m_user, input m_rdy);
  modport slave  (input m_data, m_vld, m_last, m_user, output m_rdy);
endinterface

// File: rtl/img_chunk_buf.sv
// Camera pixel packer feeding a circular BRAM FIFO with a registered stream output.
// Optional statistics counters are built only when IMG_BUF_STATS_EN is defined.
module img_chunk_buf #(
  parameter  int PIX_W         = 24,
  parameter  int PIX_PER_CHUNK = 4,
  parameter  int DEPTH         = 512,
  localparam int CHUNK_W       = PIX_W * PIX_PER_CHUNK,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [PIX_W-1:0] pdata_i,
  input  logic             pvld_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             ovf_clr_i,
  img_chunk_buf_if.master  m_if,
  output logic             ovf_o,
  output logic [AW:0]      level_o,
  output logic [15:0]      frame_cnt_o,
  output logic [15:0]      line_cnt_o,
  output logic [15:0]      drop_cnt_o
);
  localparam int CW = $clog2(PIX_PER_CHUNK + 1);

  typedef struct packed {
    logic               user;
    logic               last;
    logic [CHUNK_W-1:0] data;
  } chunk_t;

  logic                                hs_q, vs_q;
  logic [PIX_PER_CHUNK-1:0][PIX_W-1:0] acc_q, acc_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic                                sof_q, sof_d;
  logic [AW-1:0]                       wptr_q, rptr_q;
  logic [AW:0]                         level_q, level_d;
  logic                                ovf_q, ovf_d;
  logic                                out_vld_q;
  chunk_t                              out_q, wchunk;
  chunk_t                              mem [DEPTH];

  logic capture, line_end, vs_rise, full_acc, wr_req, full, wr_ok, drop, rd_en;

  assign capture  = en_i & pvld_i & hsync_i;
  assign line_end = (hs_q & ~hsync_i) | (vs_q & ~vsync_i);
  assign vs_rise  = vsync_i & ~vs_q;
  assign full_acc = (cnt_q == CW'(PIX_PER_CHUNK));
  assign wr_req   = (line_end & (cnt_q != '0)) | (capture & full_acc);
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign wr_ok    = wr_req & ~full;
  assign drop     = wr_req & full;
  // Output register doubles as the BRAM read register: refill whenever it empties this cycle.
  assign rd_en    = (level_q != '0) & (~out_vld_q | m_if.m_rdy);

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    wchunk = '0;
    wchunk.user = sof_q;
    wchunk.last = line_end;
    for (int i = 0; i < PIX_PER_CHUNK; i++)
      wchunk.data[i*PIX_W +: PIX_W] = (i < int'(cnt_q)) ? acc_q[i] : '0;
    if (capture) begin
      if (line_end | full_acc) begin
        acc_d[0] = pdata_i;
        cnt_d    = CW'(1);
      end else begin
        for (int i = 0; i < PIX_PER_CHUNK; i++)
          if (CW'(i) == cnt_q) acc_d[i] = pdata_i;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (line_end) begin
      cnt_d = '0;
    end
  end

  // A frame start landing on the same cycle as a write belongs to the next chunk.
  assign sof_d   = vs_rise ? 1'b1 : (wr_ok ? 1'b0 : sof_q);
  assign ovf_d   = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
  assign level_d = level_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_en};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sof_q     <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      hs_q    <= hsync_i;
      vs_q    <= vsync_i;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sof_q   <= sof_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_en) begin
        out_q     <= mem[rptr_q];
        out_vld_q <= 1'b1;
        rptr_q    <= rptr_q + 1'b1;
      end else if (m_if.m_rdy) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[wptr_q] <= wchunk;
  end

  assign m_if.m_data = out_q.data;
  assign m_if.m_last = out_q.last;
  assign m_if.m_user = out_q.user;
  assign m_if.m_vld  = out_vld_q;
  assign ovf_o       = ovf_q;
  assign level_o     = level_q;

`ifdef IMG_BUF_STATS_EN
  logic [15:0] frame_q, line_q, drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      line_q  <= '0;
      drop_q  <= '0;
    end else begin
      if (vs_rise) frame_q <= frame_q + 1'b1;
      if (vs_rise) line_q <= '0;
      else if (line_end && cnt_q != '0) line_q <= line_q + 1'b1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  assign frame_cnt_o = frame_q;
  assign line_cnt_o  = line_q;
  assign drop_cnt_o  = drop_q;
`else
  assign frame_cnt_o = '0;
  assign line_cnt_o  = '0;
  assign drop_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_img_chunk_buf.sv
// Scoreboard bench for img_chunk_buf: directed lines, stalls, overflow, reset, vsync flush.
module tb_img_chunk_buf;
  localparam int PIX_W = 24, PPC = 4, DEPTH = 16, CHUNK_W = 96, AW = 4;
`ifdef IMG_BUF_STATS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  typedef struct {
    logic [CHUNK_W-1:0] d;
    logic               l;
    logic               u;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, en, pvld, hsync, vsync, ovf_clr, ovf;
  logic [PIX_W-1:0] pdata;
  logic [AW:0] level;
  logic [15:0] frame_cnt, line_cnt, drop_cnt;
  logic rdy_tog = 1'b0;
  int total = 0, bad = 0;
  exp_t exp_q[$];

  img_chunk_buf_if #(.CHUNK_W(CHUNK_W)) mif();

  img_chunk_buf #(.PIX_W(PIX_W), .PIX_PER_CHUNK(PPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .pdata_i(pdata), .pvld_i(pvld),
    .hsync_i(hsync), .vsync_i(vsync), .ovf_clr_i(ovf_clr), .m_if(mif),
    .ovf_o(ovf), .level_o(level), .frame_cnt_o(frame_cnt),
    .line_cnt_o(line_cnt), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CHUNK_W-1:0] mk(int a3, int a2, int a1, int a0);
    return {24'(a3), 24'(a2), 24'(a1), 24'(a0)};
  endfunction

  task automatic check(string name, logic [CHUNK_W-1:0] act, logic [CHUNK_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(logic [CHUNK_W-1:0] d, logic l, logic u);
    exp_t e;
    e.d = d; e.l = l; e.u = u;
    exp_q.push_back(e);
  endtask

  // Expected chunks for a line of n consecutive pixel values starting at s.
  task automatic exp_line(int s, int n, logic u);
    for (int c = 0; c < n; c += PPC) begin
      logic [CHUNK_W-1:0] d;
      d = '0;
      for (int j = 0; j < PPC; j++)
        if (c + j < n) d[j*PIX_W +: PIX_W] = 24'(s + c + j);
      push(d, (c + PPC >= n), u && (c == 0));
    end
  endtask

  task automatic pix(int v);
    hsync = 1'b1; pvld = 1'b1; pdata = 24'(v);
    step();
  endtask

  task automatic send_line(int s, int n);
    for (int i = 0; i < n; i++) pix(s + i);
    pvld = 1'b0; hsync = 1'b0;
    step(); step();
  endtask

  task automatic wait_drain(string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin step(); k++; end
    repeat (4) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d chunks missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops on each transfer and checks stall stability.
  initial begin : mon
    logic [CHUNK_W-1:0] sd;
    logic sl, su, stall;
    exp_t e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          total++;
          if (!(mif.m_vld && mif.m_data == sd && mif.m_last == sl && mif.m_user == su)) begin
            bad++;
            $display("FAIL stall_stable: got vld=%0b d=%0h l=%0b u=%0b expected vld=1 d=%0h l=%0b u=%0b",
                     mif.m_vld, mif.m_data, mif.m_last, mif.m_user, sd, sl, su);
          end
        end
        if (mif.m_vld && mif.m_rdy) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_chunk: got d=%0h expected none", mif.m_data);
          end else begin
            e = exp_q.pop_front();
            if (mif.m_data !== e.d || mif.m_last !== e.l || mif.m_user !== e.u) begin
              bad++;
              $display("FAIL chunk: got d=%0h l=%0b u=%0b expected d=%0h l=%0b u=%0b",
                       mif.m_data, mif.m_last, mif.m_user, e.d, e.l, e.u);
            end
          end
        end
        stall = mif.m_vld && !mif.m_rdy;
        sd = mif.m_data; sl = mif.m_last; su = mif.m_user;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_tog) mif.m_rdy = ~mif.m_rdy;
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; pvld = 1'b0; hsync = 1'b0; vsync = 1'b0;
    ovf_clr = 1'b0; pdata = '0; mif.m_rdy = 1'b1;
    repeat (3) step();
    check("rst_vld", mif.m_vld, 0);
    check("rst_data", mif.m_data, 0);
    check("rst_last_user", {mif.m_last, mif.m_user}, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_stats", {frame_cnt, line_cnt, drop_cnt}, 0);
    rst_n = 1'b1; en = 1'b1;
    step();

    // 10-pixel line after frame start
    vsync = 1'b1; step();
    push(mk(4, 3, 2, 1), 1'b0, 1'b1);
    push(mk(8, 7, 6, 5), 1'b0, 1'b0);
    push(mk(0, 0, 10, 9), 1'b1, 1'b0);
    send_line(1, 10);
    wait_drain("line10");

    // exact multiple: no padding chunk, next line not frame start
    vsync = 1'b0; step();
    vsync = 1'b1; step();
    push(mk(4, 3, 2, 1), 1'b0, 1'b1);
    push(mk(8, 7, 6, 5), 1'b1, 1'b0);
    send_line(1, 8);
    push(mk(0, 23, 22, 21), 1'b1, 1'b0);
    send_line(21, 3);
    wait_drain("line8");
    check("level_idle", level, 0);

    // ready toggling every cycle
    rdy_tog = 1'b1;
    exp_line(100, 7, 1'b0);  send_line(100, 7);
    exp_line(200, 12, 1'b0); send_line(200, 12);
    exp_line(300, 5, 1'b0);  send_line(300, 5);
    wait_drain("toggle");
    rdy_tog = 1'b0; step();
    mif.m_rdy = 1'b1; step();

    // overflow: 19 chunks against 16 entries + output register
    mif.m_rdy = 1'b0;
    for (int c = 0; c < 17; c++) push(mk(4*c+4, 4*c+3, 4*c+2, 4*c+1), 1'b0, 1'b0);
    send_line(1, 76);
    check("ovf_level", level, 16);
    check("ovf_flag", ovf, 1);
    check("ovf_vld", mif.m_vld, 1);
    check("ovf_drop_cnt", drop_cnt, ST ? 16'd2 : 16'd0);
    mif.m_rdy = 1'b1;
    wait_drain("overflow");
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // reset mid-line with two chunks buffered
    mif.m_rdy = 1'b0;
    for (int i = 1; i <= 12; i++) pix(i);
    pvld = 1'b0; step(); step();
    check("pre_rst_vld", mif.m_vld, 1);
    check("pre_rst_level", level, 1);
    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0;
    step();
    check("mid_rst_vld", mif.m_vld, 0);
    check("mid_rst_data", mif.m_data, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1; mif.m_rdy = 1'b1; step();
    push(mk(53, 52, 51, 50), 1'b1, 1'b1);
    send_line(50, 4);
    wait_drain("post_rst");

    // vsync falls with a partial chunk while hsync is still high
    vsync = 1'b1; step();
    exp_line(60, 5, 1'b1);
    send_line(60, 5);
    push(mk(73, 72, 71, 70), 1'b0, 1'b0);
    push(mk(0, 0, 75, 74), 1'b1, 1'b0);
    for (int i = 70; i <= 75; i++) pix(i);
    pvld = 1'b0; vsync = 1'b0; step();
    hsync = 1'b0; step(); step();
    wait_drain("vsync_flush");
    check("frame_cnt", frame_cnt, ST ? 16'd1 : 16'd0);
    check("line_cnt", line_cnt, ST ? 16'd2 : 16'd0);
    check("final_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
